// File: rtl/mem_cmd_sched_pkg.sv
// Shared constants, state encoding and helpers for the memory command scheduler.
package mem_sched_pkg;

  localparam int unsigned NUM_SRC = 4;
  localparam int unsigned SRC_W   = 2;

  localparam logic [SRC_W-1:0] SRC_MEM_INIT = 2'd0;
  localparam logic [SRC_W-1:0] SRC_MEM_TEST = 2'd1;
  localparam logic [SRC_W-1:0] SRC_FIFO_WR  = 2'd2;
  localparam logic [SRC_W-1:0] SRC_FIFO_RD  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

  function automatic logic [NUM_SRC-1:0] src_onehot(input logic [SRC_W-1:0] idx);
    return NUM_SRC'(1) << idx;
  endfunction

endpackage

// File: rtl/mem_cmd_sched_if.sv
// Request/completion/status bundle between register block, engines and scheduler.
interface mem_cmd_sched_if;
  import mem_sched_pkg::*;

  logic [NUM_SRC-1:0] req_i;
  logic [NUM_SRC-1:0] done_i;
  logic               clr_err_i;
  logic [NUM_SRC-1:0] start_o;
  logic [NUM_SRC-1:0] grant_o;
  logic               busy_o;
  logic [NUM_SRC-1:0] pending_o;
  logic               err_o;
  logic [SRC_W-1:0]   err_src_o;

  modport master (
    output req_i, done_i, clr_err_i,
    input  start_o, grant_o, busy_o, pending_o, err_o, err_src_o
  );

  modport slave (
    input  req_i, done_i, clr_err_i,
    output start_o, grant_o, busy_o, pending_o, err_o, err_src_o
  );
endinterface

// File: rtl/mem_cmd_sched_rr_arbiter4.sv
// Combinational round-robin pick: first pending bit at or after rr_ptr, wrapping 3->0.
module rr_arbiter4
  import mem_sched_pkg::*;
(
  input  logic [NUM_SRC-1:0] pending,
  input  logic [SRC_W-1:0]   rr_ptr,
  output logic [SRC_W-1:0]   win,
  output logic               valid
);

  logic [SRC_W-1:0] idx;

  // Scan from farthest to nearest so the nearest pending bit is the last write.
  always_comb begin
    valid = 1'b0;
    win   = rr_ptr;
    idx   = rr_ptr;
    for (int k = int'(NUM_SRC) - 1; k >= 0; k--) begin
      idx = rr_ptr + SRC_W'(k);
      if (pending[idx]) begin
        valid = 1'b1;
        win   = idx;
      end
    end
  end

endmodule

// File: rtl/mem_cmd_sched.sv
// Serialises the four memory engines onto the shared DDR3 port: latch, arbitrate, start, hold grant.
// Optional watchdog/error reporting is built when MEM_SCHED_TIMEOUT_EN is defined.
module mem_cmd_sched
  import mem_sched_pkg::*;
#(
  parameter int unsigned           TIMEOUT_W   = 24,
  parameter logic [TIMEOUT_W-1:0]  TIMEOUT_CYC = TIMEOUT_W'(24'hFF_FFFF)
) (
  input  logic              clk_i,
  input  logic              resetn_i,
  mem_cmd_sched_if.slave    bus
);

  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] start_q, start_d;
  logic [NUM_SRC-1:0] grant_q, grant_d;
  logic [SRC_W-1:0]   rr_q, rr_d;
  logic [SRC_W-1:0]   win_q, win_d;
  logic               busy_q;
  logic [SRC_W-1:0]   arb_win;
  logic               arb_valid;
  logic               timeout_c;
  logic               abort_c;

  rr_arbiter4 u_arb (
    .pending (pending_q),
    .rr_ptr  (rr_q),
    .win     (arb_win),
    .valid   (arb_valid)
  );

  // A done on the same edge as the watchdog limit counts as a normal completion.
  assign abort_c = (state_q == ST_RUN) && !bus.done_i[win_q] && timeout_c;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    rr_d      = rr_q;
    win_d     = win_q;
    start_d   = '0;
    grant_d   = grant_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          state_d            = ST_START;
          win_d              = arb_win;
          start_d            = src_onehot(arb_win);
          grant_d            = src_onehot(arb_win);
          pending_d[arb_win] = 1'b0;
          rr_d               = arb_win + SRC_W'(1);
        end
      end
      ST_START: state_d = ST_RUN;
      ST_RUN: begin
        if (bus.done_i[win_q] || abort_c) begin
          state_d = ST_GAP;
          grant_d = '0;
        end
      end
      ST_GAP:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    // New requests override the clear of the source being started.
    pending_d = pending_d | bus.req_i;
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      start_q   <= '0;
      grant_q   <= '0;
      rr_q      <= '0;
      win_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      start_q   <= start_d;
      grant_q   <= grant_d;
      rr_q      <= rr_d;
      win_q     <= win_d;
      busy_q    <= (state_d != ST_IDLE);
    end
  end

`ifdef MEM_SCHED_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic [SRC_W-1:0]     err_src_q, err_src_d;

  assign timeout_c = (cnt_q == TIMEOUT_CYC - TIMEOUT_W'(1));

  // Clear is applied first so a coincident timeout re-sets the error.
  always_comb begin
    cnt_d     = cnt_q;
    err_d     = err_q;
    err_src_d = err_src_q;
    if (bus.clr_err_i) begin
      err_d     = 1'b0;
      err_src_d = '0;
    end
    if (state_q == ST_START) begin
      cnt_d = '0;
    end else if (state_q == ST_RUN) begin
      if (abort_c) begin
        err_d     = 1'b1;
        err_src_d = win_q;
      end else begin
        cnt_d = cnt_q + TIMEOUT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      cnt_q     <= '0;
      err_q     <= 1'b0;
      err_src_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      err_src_q <= err_src_d;
    end
  end

  assign bus.err_o     = err_q;
  assign bus.err_src_o = err_src_q;
`else
  logic unused_cfg;

  assign timeout_c     = 1'b0;
  assign unused_cfg    = ^{bus.clr_err_i, TIMEOUT_CYC};
  assign bus.err_o     = 1'b0;
  assign bus.err_src_o = '0;
`endif

  assign bus.start_o   = start_q;
  assign bus.grant_o   = grant_q;
  assign bus.busy_o    = busy_q;
  assign bus.pending_o = pending_q;

endmodule

// File: doc/mem_cmd_sched.md
# mem_cmd_sched

Scheduler sitting between the register-side enable pulse generator and the four memory engines: pattern generator (mem init), pattern checker (mem test), DIGIFIFO→DDR3 transfer and DDR3→MEMFIFO transfer. These engines share one DDR3 controller port, so only one may run at a time. The block latches single-cycle request pulses, arbitrates round-robin, issues a one-cycle start to the winning engine, and holds it granted until its done pulse or a watchdog timeout. Busy, pending and error status are returned to the register block.

## Interface
- TIMEOUT_W, 24: width of the watchdog counter.
- TIMEOUT_CYC, 24'hFF_FFFF: RUN cycles allowed before abort; must be ≥ 2.
- clk_i  in  1  system clock; all logic on its rising edge.
- resetn_i  in  1  reset, asynchronous assert, active-low.
- req_i  in  4  request pulses: [0] mem_init, [1] mem_test, [2] fifo_write_mem, [3] fifo_read_mem.
- done_i  in  4  completion pulses from the engines, same bit order.
- clr_err_i  in  1  clears err_o and err_src_o.
- start_o  out  4  one-hot, one-cycle start pulse to the selected engine.
- grant_o  out  4  one-hot; high from the start cycle until the operation ends.
- busy_o  out  1  high in every state except IDLE.
- pending_o  out  4  latched, not-yet-started requests.
- err_o  out  1  sticky timeout flag.
- err_src_o  out  2  index of the source that timed out.

## Operation
- **Pending bits:** pending[i] is set by req_i[i] and cleared when source i enters START. If set and clear fall on the same cycle, set wins. A repeat request while a bit is already pending coalesces into that one bit. A request from the running source re-arms its pending bit.
- **States:** IDLE, START, RUN, GAP.
- **IDLE → START:** when pending ≠ 0. The winner is the first pending bit at or after rr_ptr, wrapping 3→0.
- **START:** lasts one cycle. Drives start_o[win] = 1 and grant_o[win] = 1, clears pending[win], and sets rr_ptr = (win+1) mod 4. Goes to RUN.
- **RUN:** grant held and watchdog counting.
  - done_i[win] = 1 → GAP.
  - done_i on non-granted bits is ignored.
- **Watchdog abort:** when the counter reaches TIMEOUT_CYC without done, go to GAP, set err_o = 1 and load err_src_o = win.
- **GAP:** lasts one cycle with grant_o = 0 (bus turnaround), then returns to IDLE.
- **clr_err_i:** clears err_o and err_src_o. If it coincides with a new timeout, the new timeout wins.
- **Reset:** may arrive mid-operation. Everything returns to reset values immediately, and the in-flight engine is simply dropped.

## Timing
- **Reset values:** start_o = 0, grant_o = 0, busy_o = 0, pending_o = 0, err_o = 0, err_src_o = 0, rr_ptr = 0, state = IDLE.
- All outputs are registered.
- **Request to start:** req_i at edge N sets pending after N. If the block is IDLE, START state and start_o are visible after edge N+1 (latency 2 edges).
- **Done:** done_i is sampled only in RUN, so a done during START is ignored. done_i[win] at edge M drops grant_o after M. The next start_o appears after M+2.
- **Watchdog:** counter is cleared in START and increments each RUN cycle; abort happens on the edge where counter == TIMEOUT_CYC−1.

## Configuration
- MEM_SCHED_TIMEOUT_EN defined: watchdog, err_o and err_src_o function as described.
- Undefined: RUN waits indefinitely for done_i. The counter is not built, err_o and err_src_o are tied 0, clr_err_i is ignored, and TIMEOUT_W and TIMEOUT_CYC are unused.

## Structure
- **mem_sched_pkg:**
  - source index constants SRC_MEM_INIT = 0, SRC_MEM_TEST = 1, SRC_FIFO_WR = 2, SRC_FIFO_RD = 3;
  - state encoding constants;
  - NUM_SRC = 4.
- **Sub-module rr_arbiter4:** combinational. Takes pending[3:0] and rr_ptr[1:0], returns win[1:0] and valid. The FSM, pending bits and watchdog stay in mem_cmd_sched.

## Test plan
- **Single request:** reset, then pulse req_i = 4'b0001. Expect start_o = 0001 for one cycle two edges later and grant_o = 0001 held. done_i = 0001 → grant_o = 0 next cycle, busy_o low one cycle after that.
- **Simultaneous requests:** req_i = 4'b1111 in one cycle, each done returned 5 cycles after its start. Expect grant order 0, 1, 2, 3, grant gaps of one cycle, and pending_o stepping 1111 → 1110 → 1100 → 1000 → 0000.
- **Fairness:** hold sources 0 and 2 re-requesting constantly. Expect grants to alternate 0, 2, 0, 2 with no starvation.
- **Watchdog (with MEM_SCHED_TIMEOUT_EN, TIMEOUT_CYC = 16):** start source 3 and never send done. Expect grant dropped after 16 RUN cycles, err_o = 1, err_src_o = 3. Then clr_err_i → err_o = 0.
- **Reset mid-RUN:** assert resetn_i low mid-RUN with source 2 pending. Expect all outputs 0 immediately and no start after release until a new request.
- **Stray and re-armed signals:** done_i on a non-granted bit, or during START, is ignored and grant stays. A req for the running source re-sets its pending bit, and it is served again after GAP.
